// File: rtl/cache_packet_gen_pkg.sv
// Shared definitions for the cache traffic generator: packet field layout,
// block geometry, per-way state encoding and request-building helpers.
package cache_packet_gen_pkg;

  localparam int CPU_ADDR_LEN       = 32;
  localparam int WORD_BITS          = 32;
  localparam int WORDS_PER_BLOCK    = 4;
  localparam int BLOCK_SIZE_IN_BITS = WORD_BITS * WORDS_PER_BLOCK;
  localparam int BLOCK_OFFSET_BITS  = 4;
  localparam int BYTE_MASK_LEN      = BLOCK_SIZE_IN_BITS / 8;
  localparam int PORT_NUM_LEN       = 4;
  localparam int TYPE_LEN           = 2;

  localparam logic [CPU_ADDR_LEN-1:0] BASE_ADDR = '0;

  // Packet layout, LSB first.
  localparam int VALID        = 0;
  localparam int IS_WRITE     = 1;
  localparam int CACHEABLE    = 2;
  localparam int TYPE_LO      = 3;
  localparam int TYPE_HI      = TYPE_LO + TYPE_LEN - 1;
  localparam int PORT_NUM_LO  = TYPE_HI + 1;
  localparam int PORT_NUM_HI  = PORT_NUM_LO + PORT_NUM_LEN - 1;
  localparam int BYTE_MASK_LO = PORT_NUM_HI + 1;
  localparam int BYTE_MASK_HI = BYTE_MASK_LO + BYTE_MASK_LEN - 1;
  localparam int ADDR_LO      = BYTE_MASK_HI + 1;
  localparam int ADDR_HI      = ADDR_LO + CPU_ADDR_LEN - 1;
  localparam int DATA_LO      = ADDR_HI + 1;
  localparam int DATA_HI      = DATA_LO + BLOCK_SIZE_IN_BITS - 1;
  localparam int UNIFIED_CACHE_PACKET_WIDTH_IN_BITS = DATA_HI + 1;

  typedef enum logic [2:0] {
    WR_SEND = 3'd0,
    RD_SEND = 3'd1,
    RD_WAIT = 3'd2,
    FIN     = 3'd3,
    ERR     = 3'd4
  } way_state_e;

  function automatic logic [CPU_ADDR_LEN-1:0] block_addr(input logic [31:0] idx,
                                                          input logic [31:0] way,
                                                          input logic [31:0] num_way);
    return ((idx * num_way + way) << BLOCK_OFFSET_BITS) + BASE_ADDR;
  endfunction

  function automatic logic [BLOCK_SIZE_IN_BITS-1:0] block_data(input logic [CPU_ADDR_LEN-1:0] addr);
    logic [BLOCK_SIZE_IN_BITS-1:0] data;
    data = '0;
    for (int k = 0; k < WORDS_PER_BLOCK; k++)
      data[k*WORD_BITS +: WORD_BITS] = addr + WORD_BITS'(4 * k);
    return data;
  endfunction

  function automatic logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] make_request(
      input logic [CPU_ADDR_LEN-1:0] addr,
      input logic                    is_write,
      input logic [PORT_NUM_LEN-1:0] port);
    logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] p;
    p = '0;
    p[VALID]                     = 1'b1;
    p[IS_WRITE]                  = is_write;
    p[CACHEABLE]                 = 1'b1;
    p[PORT_NUM_HI:PORT_NUM_LO]   = port;
    p[BYTE_MASK_HI:BYTE_MASK_LO] = '1;
    p[ADDR_HI:ADDR_LO]           = addr;
    p[DATA_HI:DATA_LO]           = block_data(addr);
    return p;
  endfunction

endpackage

// File: rtl/cache_packet_gen_way.sv
// One port of the traffic generator: write-then-read-back FSM with timeout.
// CACHE_PACKET_GEN_STOP_ON_ERROR_EN lets a failing sibling way abort this one.
module cache_packet_gen_way
  import cache_packet_gen_pkg::*;
#(
  parameter int NUM_WAY          = 2,
  parameter int WAY_ID           = 0,
  parameter int NUM_REQUEST      = 16,
  parameter int TIMING_OUT_CYCLE = 1000
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          req_ack_in,
  input  logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] return_packet_in,
  input  logic                                          force_err_in,
  output logic [UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] packet_out,
  output logic                                          return_ack_out,
  output logic                                          err_raw_out,
  output way_state_e                                    state_out
);
  localparam int PW = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;
  localparam int IW = $clog2(NUM_REQUEST + 1);
  localparam int CW = $clog2(TIMING_OUT_CYCLE + 2);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQUEST - 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMING_OUT_CYCLE);

  way_state_e            state_q, state_d, state_own;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         pkt_q, pkt_d;
  logic                  ret_ack_q, ret_ack_d;
  logic                  req_fire, ret_fire, ret_is_read, active, match;
  logic [CPU_ADDR_LEN-1:0] exp_addr;
  logic                  unused_bits;

  always_comb begin
    exp_addr    = block_addr(32'(idx_q), 32'(WAY_ID), 32'(NUM_WAY));
    // An ack only counts while a request is actually on the bus.
    req_fire    = req_ack_in && pkt_q[VALID];
    // The cycle our ack is high the cache still holds the same return.
    ret_fire    = return_packet_in[VALID] && !ret_ack_q;
    ret_is_read = ret_fire && !return_packet_in[IS_WRITE];
    match       = (return_packet_in[ADDR_HI:ADDR_LO] == exp_addr) &&
                  (return_packet_in[DATA_HI:DATA_LO] == block_data(exp_addr));
    active      = state_q inside {WR_SEND, RD_SEND, RD_WAIT};
    state_own   = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    ret_ack_d   = ret_fire;

    case (state_q)
      WR_SEND: if (req_fire) begin
        if (idx_q == LAST_IDX) begin
          idx_d     = '0;
          state_own = RD_SEND;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      RD_SEND: if (req_fire) state_own = RD_WAIT;
      RD_WAIT: if (ret_is_read) begin
        if (!match)                state_own = ERR;
        else if (idx_q == LAST_IDX) state_own = FIN;
        else begin
          idx_d     = idx_q + 1'b1;
          state_own = RD_SEND;
        end
      end
      default: ;
    endcase

    if (active) begin
      cnt_d = (req_fire || ret_fire) ? '0 : cnt_q + 1'b1;
      if (ret_is_read && state_q != RD_WAIT) state_own = ERR;
      if (cnt_q > TO_LIMIT)                  state_own = ERR;
    end

    state_d = state_own;
`ifdef CACHE_PACKET_GEN_STOP_ON_ERROR_EN
    if (force_err_in && active) state_d = ERR;
    unused_bits = ^return_packet_in;
`else
    unused_bits = ^{return_packet_in, force_err_in};
`endif

    pkt_d = '0;
    if (state_d == WR_SEND)
      pkt_d = make_request(block_addr(32'(idx_d), 32'(WAY_ID), 32'(NUM_WAY)), 1'b1,
                           PORT_NUM_LEN'(WAY_ID));
    else if (state_d == RD_SEND)
      pkt_d = make_request(block_addr(32'(idx_d), 32'(WAY_ID), 32'(NUM_WAY)), 1'b0,
                           PORT_NUM_LEN'(WAY_ID));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WR_SEND;
      idx_q     <= '0;
      cnt_q     <= '0;
      pkt_q     <= '0;
      ret_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      pkt_q     <= pkt_d;
      ret_ack_q <= ret_ack_d;
    end
  end

  assign packet_out     = pkt_q;
  assign return_ack_out = ret_ack_q;
  assign err_raw_out    = (state_own == ERR);
  assign state_out      = state_q;

endmodule

// File: rtl/cache_packet_gen.sv
// Multi-port cache traffic generator top: per-way FSMs plus done/error reduction.
// Optional build macro: CACHE_PACKET_GEN_STOP_ON_ERROR_EN.
module cache_packet_gen
  import cache_packet_gen_pkg::*;
#(
  parameter int NUM_WAY          = 2,
  parameter int NUM_REQUEST      = 16,
  parameter int TIMING_OUT_CYCLE = 1000
) (
  input  logic                                                  clk_in,
  input  logic                                                  reset_in,
  output logic [NUM_WAY*UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] test_packet_flatted_out,
  input  logic [NUM_WAY-1:0]                                    test_packet_ack_flatted_in,
  input  logic [NUM_WAY*UNIFIED_CACHE_PACKET_WIDTH_IN_BITS-1:0] return_packet_flatted_in,
  output logic [NUM_WAY-1:0]                                    return_packet_ack_flatted_out,
  output logic                                                  done,
  output logic                                                  error
);
  localparam int PW = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;

  logic [NUM_WAY-1:0] err_raw, way_err, way_end, force_err;
  way_state_e         way_state [NUM_WAY];
  logic               done_q, done_d, error_q, error_d;

  generate
    for (genvar gi = 0; gi < NUM_WAY; gi++) begin : g_way
      cache_packet_gen_way #(
        .NUM_WAY         (NUM_WAY),
        .WAY_ID          (gi),
        .NUM_REQUEST     (NUM_REQUEST),
        .TIMING_OUT_CYCLE(TIMING_OUT_CYCLE)
      ) u_way (
        .clk             (clk_in),
        .rst             (reset_in),
        .req_ack_in      (test_packet_ack_flatted_in[gi]),
        .return_packet_in(return_packet_flatted_in[gi*PW +: PW]),
        .force_err_in    (force_err[gi]),
        .packet_out      (test_packet_flatted_out[gi*PW +: PW]),
        .return_ack_out  (return_packet_ack_flatted_out[gi]),
        .err_raw_out     (err_raw[gi]),
        .state_out       (way_state[gi])
      );
      // Siblings abort on the same edge, so done and error can rise together.
      assign force_err[gi] = |(err_raw & ~(NUM_WAY'(1) << gi));
      assign way_err[gi]   = (way_state[gi] == ERR);
      assign way_end[gi]   = (way_state[gi] == FIN) || (way_state[gi] == ERR);
    end
  endgenerate

  always_comb begin
    done_d  = &way_end;
    error_d = |way_err;
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign done  = done_q;
  assign error = error_q;

endmodule

// File: tb/tb_cache_packet_gen.sv
// Directed bench for cache_packet_gen with an ideal cache model
// (one-cycle ack, read return ten cycles later, backing memory).
module tb_cache_packet_gen;
  import cache_packet_gen_pkg::*;

  localparam int NW = 2;
  localparam int NR = 16;
  localparam int TO = 1000;
  localparam int PW = UNIFIED_CACHE_PACKET_WIDTH_IN_BITS;

  logic clk_in = 1'b0;
  logic reset_in = 1'b1;
  logic [NW*PW-1:0] test_packet_flatted_out;
  logic [NW-1:0]    test_packet_ack_flatted_in = '0;
  logic [NW*PW-1:0] return_packet_flatted_in = '0;
  logic [NW-1:0]    return_packet_ack_flatted_out;
  logic done, error;

  int errors = 0;
  int checks = 0;
  logic noack_w0 = 1'b0, corrupt_en = 1'b0, wresp_en = 1'b0;

  typedef struct {
    int unsigned     due;
    logic [PW-1:0]   pkt;
  } ret_t;

  ret_t          rq [NW][$];
  logic [PW-1:0] ret_cur [NW];
  logic [127:0]  mem [logic [31:0]];
  int n_wr_w [NW];
  int n_rd_w [NW];
  int n_bad, n_presented, n_ackhigh, n_wresp_acked;
  int unsigned cyc;

  cache_packet_gen #(.NUM_WAY(NW), .NUM_REQUEST(NR), .TIMING_OUT_CYCLE(TO)) dut (
    .clk_in                       (clk_in),
    .reset_in                     (reset_in),
    .test_packet_flatted_out      (test_packet_flatted_out),
    .test_packet_ack_flatted_in   (test_packet_ack_flatted_in),
    .return_packet_flatted_in     (return_packet_flatted_in),
    .return_packet_ack_flatted_out(return_packet_ack_flatted_out),
    .done                         (done),
    .error                        (error)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [127:0] exp_block(input logic [31:0] a);
    return {a + 32'd12, a + 32'd8, a + 32'd4, a};
  endfunction

  // Ideal cache model, evaluated on the falling edge.
  always @(negedge clk_in) begin : model
    logic [PW-1:0] p, r;
    logic [31:0]   a;
    ret_t          t;
    if (reset_in) begin
      cyc = 0;
      n_bad = 0; n_presented = 0; n_ackhigh = 0; n_wresp_acked = 0;
      mem.delete();
      test_packet_ack_flatted_in = '0;
      return_packet_flatted_in = '0;
      for (int w = 0; w < NW; w++) begin
        rq[w].delete();
        ret_cur[w] = '0;
        n_wr_w[w] = 0;
        n_rd_w[w] = 0;
      end
    end else begin
      cyc++;
      for (int w = 0; w < NW; w++) begin
        p = test_packet_flatted_out[w*PW +: PW];
        if (test_packet_ack_flatted_in[w]) begin
          test_packet_ack_flatted_in[w] = 1'b0;
        end else if (p[VALID] && !(noack_w0 && w == 0)) begin
          test_packet_ack_flatted_in[w] = 1'b1;
          a = p[ADDR_HI:ADDR_LO];
          if (p[IS_WRITE]) begin
            if (a !== 32'((n_wr_w[w] * NW + w) * 16) || p[DATA_HI:DATA_LO] !== exp_block(a) ||
                p[BYTE_MASK_HI:BYTE_MASK_LO] !== {BYTE_MASK_LEN{1'b1}} ||
                p[PORT_NUM_HI:PORT_NUM_LO] !== PORT_NUM_LEN'(w) ||
                p[TYPE_HI:TYPE_LO] !== 2'b00 || p[CACHEABLE] !== 1'b1)
              n_bad++;
            n_wr_w[w]++;
            mem[a] = p[DATA_HI:DATA_LO];
            if (wresp_en) begin
              r = '0; r[VALID] = 1'b1; r[IS_WRITE] = 1'b1; r[ADDR_HI:ADDR_LO] = a;
              t.due = cyc + 2; t.pkt = r;
              rq[w].push_back(t);
            end
          end else begin
            if (a !== 32'((n_rd_w[w] * NW + w) * 16) || p[CACHEABLE] !== 1'b1 ||
                p[PORT_NUM_HI:PORT_NUM_LO] !== PORT_NUM_LEN'(w))
              n_bad++;
            r = '0; r[VALID] = 1'b1; r[ADDR_HI:ADDR_LO] = a;
            r[DATA_HI:DATA_LO] = mem.exists(a) ? mem[a] : '0;
            if (corrupt_en && w == 1 && n_rd_w[w] == 3) r[DATA_LO] = ~r[DATA_LO];
            n_rd_w[w]++;
            t.due = cyc + 10; t.pkt = r;
            rq[w].push_back(t);
          end
        end
        if (return_packet_ack_flatted_out[w]) n_ackhigh++;
        if (ret_cur[w][VALID]) begin
          if (return_packet_ack_flatted_out[w]) begin
            if (ret_cur[w][IS_WRITE]) n_wresp_acked++;
            ret_cur[w] = '0;
          end
        end else if (rq[w].size() > 0 && rq[w][0].due <= cyc) begin
          t = rq[w].pop_front();
          ret_cur[w] = t.pkt;
          n_presented++;
        end
        return_packet_flatted_in[w*PW +: PW] = ret_cur[w];
      end
    end
  end

  task automatic do_reset();
    @(negedge clk_in);
    reset_in = 1'b1;
    repeat (3) @(negedge clk_in);
    reset_in = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && done !== 1'b1; k++) @(negedge clk_in);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_in);
    checks++; if (test_packet_flatted_out !== '0) begin errors++; $display("FAIL reset_packet: got %0h expected 0", test_packet_flatted_out); end
    checks++; if (return_packet_ack_flatted_out !== '0) begin errors++; $display("FAIL reset_ret_ack: got %b expected 00", return_packet_ack_flatted_out); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", error); end
    $display("test_reset: outputs after reset checked");
  endtask

  task automatic test_normal();
    logic [PW-1:0] exp_pkt;
    noack_w0 = 1'b0; corrupt_en = 1'b0; wresp_en = 1'b0;
    do_reset();
    @(negedge clk_in);
    exp_pkt = '0;
    exp_pkt[VALID] = 1'b1; exp_pkt[IS_WRITE] = 1'b1; exp_pkt[CACHEABLE] = 1'b1;
    exp_pkt[BYTE_MASK_HI:BYTE_MASK_LO] = '1;
    exp_pkt[DATA_HI:DATA_LO] = {32'd12, 32'd8, 32'd4, 32'd0};
    checks++; if (test_packet_flatted_out[PW-1:0] !== exp_pkt) begin errors++; $display("FAIL first_write_way0: got %0h expected %0h", test_packet_flatted_out[PW-1:0], exp_pkt); end
    checks++; if (test_packet_flatted_out[PW+ADDR_LO +: 32] !== 32'h10) begin errors++; $display("FAIL first_write_way1_addr: got %0h expected 10", test_packet_flatted_out[PW+ADDR_LO +: 32]); end
    checks++; if (test_packet_flatted_out[PW+PORT_NUM_LO +: PORT_NUM_LEN] !== 4'd1) begin errors++; $display("FAIL first_write_way1_port: got %0d expected 1", test_packet_flatted_out[PW+PORT_NUM_LO +: PORT_NUM_LEN]); end
    wait_done(1500);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL normal_done: got %b expected 1", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL normal_error: got %b expected 0", error); end
    repeat (20) @(negedge clk_in);
    checks++; if (n_wr_w[0] + n_wr_w[1] !== 32) begin errors++; $display("FAIL normal_writes: got %0d expected 32", n_wr_w[0] + n_wr_w[1]); end
    checks++; if (n_rd_w[0] + n_rd_w[1] !== 32) begin errors++; $display("FAIL normal_reads: got %0d expected 32", n_rd_w[0] + n_rd_w[1]); end
    checks++; if (n_bad !== 0) begin errors++; $display("FAIL normal_req_fields: got %0d bad requests expected 0", n_bad); end
    checks++; if (n_ackhigh !== n_presented) begin errors++; $display("FAIL normal_ret_ack_pulses: got %0d expected %0d", n_ackhigh, n_presented); end
    checks++; if (test_packet_flatted_out !== '0) begin errors++; $display("FAIL fin_packet_zero: got %0h expected 0", test_packet_flatted_out); end
    $display("test_normal: writes=%0d reads=%0d done=%b error=%b", n_wr_w[0] + n_wr_w[1], n_rd_w[0] + n_rd_w[1], done, error);
  endtask

  task automatic test_corrupt();
    int k;
    noack_w0 = 1'b0; corrupt_en = 1'b1; wresp_en = 1'b0;
    do_reset();
    k = 0;
    while (error !== 1'b1 && k < 1500) begin @(negedge clk_in); k++; end
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL corrupt_error: got %b expected 1", error); end
`ifdef CACHE_PACKET_GEN_STOP_ON_ERROR_EN
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL stop_done_with_error: got %b expected 1", done); end
    repeat (20) @(negedge clk_in);
    checks++; if (n_rd_w[0] >= NR) begin errors++; $display("FAIL stop_way0_aborted: got %0d reads expected fewer than %0d", n_rd_w[0], NR); end
`else
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL corrupt_done_early: got %b expected 0", done); end
    wait_done(1500);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL corrupt_done_later: got %b expected 1", done); end
    repeat (20) @(negedge clk_in);
    checks++; if (n_rd_w[0] !== NR) begin errors++; $display("FAIL corrupt_way0_reads: got %0d expected %0d", n_rd_w[0], NR); end
`endif
    checks++; if (n_rd_w[1] !== 4) begin errors++; $display("FAIL corrupt_way1_reads: got %0d expected 4", n_rd_w[1]); end
    $display("test_corrupt: error=%b done=%b reads0=%0d reads1=%0d", error, done, n_rd_w[0], n_rd_w[1]);
    corrupt_en = 1'b0;
  endtask

  task automatic test_timeout();
    noack_w0 = 1'b1; corrupt_en = 1'b0; wresp_en = 1'b0;
    do_reset();
    repeat (TO) @(negedge clk_in);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL timeout_early_error: got %b expected 0", error); end
    checks++; if (test_packet_flatted_out[ADDR_LO +: 32] !== 32'h0 || test_packet_flatted_out[VALID] !== 1'b1 || test_packet_flatted_out[IS_WRITE] !== 1'b1) begin
      errors++; $display("FAIL timeout_held_write: got addr %0h valid %b expected addr 0 valid 1", test_packet_flatted_out[ADDR_LO +: 32], test_packet_flatted_out[VALID]);
    end
    repeat (4) @(negedge clk_in);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout_error: got %b expected 1", error); end
    wait_done(500);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL timeout_done: got %b expected 1", done); end
    $display("test_timeout: error=%b done=%b", error, done);
    noack_w0 = 1'b0;
  endtask

  task automatic test_write_resp();
    noack_w0 = 1'b0; corrupt_en = 1'b0; wresp_en = 1'b1;
    do_reset();
    wait_done(1500);
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL wresp_done: got %b expected 1", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL wresp_error: got %b expected 0", error); end
    repeat (20) @(negedge clk_in);
    checks++; if (n_wresp_acked !== 32) begin errors++; $display("FAIL wresp_acked: got %0d expected 32", n_wresp_acked); end
    checks++; if (n_ackhigh !== n_presented) begin errors++; $display("FAIL wresp_ack_pulses: got %0d expected %0d", n_ackhigh, n_presented); end
    $display("test_write_resp: responses acked=%0d done=%b error=%b", n_wresp_acked, done, error);
    wresp_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k;
    noack_w0 = 1'b0; corrupt_en = 1'b0; wresp_en = 1'b0;
    do_reset();
    k = 0;
    while (n_rd_w[0] + n_rd_w[1] < 4 && k < 500) begin @(negedge clk_in); k++; end
    checks++; if (n_rd_w[0] + n_rd_w[1] < 4) begin errors++; $display("FAIL mid_reach_reads: got %0d expected at least 4", n_rd_w[0] + n_rd_w[1]); end
    repeat (2) @(negedge clk_in);
    #2 reset_in = 1'b1;
    #1;
    checks++; if (test_packet_flatted_out !== '0) begin errors++; $display("FAIL mid_reset_packet: got %0h expected 0", test_packet_flatted_out); end
    checks++; if (return_packet_ack_flatted_out !== '0) begin errors++; $display("FAIL mid_reset_ret_ack: got %b expected 00", return_packet_ack_flatted_out); end
    checks++; if (done !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: got done=%b error=%b expected 0 0", done, error); end
    repeat (3) @(negedge clk_in);
    reset_in = 1'b0;
    @(negedge clk_in);
    checks++; if (test_packet_flatted_out[ADDR_LO +: 32] !== 32'h0 || test_packet_flatted_out[IS_WRITE] !== 1'b1 || test_packet_flatted_out[VALID] !== 1'b1) begin
      errors++; $display("FAIL mid_restart_write: got addr %0h wr %b expected addr 0 wr 1", test_packet_flatted_out[ADDR_LO +: 32], test_packet_flatted_out[IS_WRITE]);
    end
    wait_done(1500);
    checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL mid_restart_complete: got done=%b error=%b expected 1 0", done, error); end
    repeat (20) @(negedge clk_in);
    checks++; if (n_wr_w[0] + n_wr_w[1] !== 32 || n_bad !== 0) begin errors++; $display("FAIL mid_restart_writes: got %0d writes %0d bad expected 32 0", n_wr_w[0] + n_wr_w[1], n_bad); end
    $display("test_reset_mid: restart done=%b error=%b", done, error);
  endtask

  initial begin
    test_reset();
    test_normal();
    test_corrupt();
    test_timeout();
    test_write_resp();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
